// File: rtl/sink_arbiter.sv
// sink_arbiter: round-robin arbiter that shares one two-phase (toggle)
// req/ack output channel among N_PORTS two-phase requesters. A pending
// port is granted, its flit is captured and forwarded, and the
// requester's ack toggle is returned once the downstream acknowledges.
module sink_arbiter #(
   parameter int N_PORTS  = 4,
   parameter int SIZE     = 8,
   parameter int PTR_BITS = 2,
   parameter int CNT_BITS = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_PORTS-1:0]        in_req,
   output logic [N_PORTS-1:0]        in_ack,
   input  logic [N_PORTS*SIZE-1:0]   in_data,
   output logic                      out_req,
   input  logic                      out_ack,
   output logic [SIZE-1:0]           out_data,
   output logic [PTR_BITS-1:0]       grant_id,
   output logic                      busy,
   output logic [CNT_BITS-1:0]       xfer_count
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [PTR_BITS-1:0]   ptr_q, ptr_d;
   logic [N_PORTS-1:0]    in_ack_q, in_ack_d;
   logic                  out_req_q, out_req_d;
   logic [SIZE-1:0]       out_data_q, out_data_d;
   logic [PTR_BITS-1:0]   grant_q, grant_d;
   logic                  busy_q, busy_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;

   logic [N_PORTS-1:0]    pending;
   logic [N_PORTS-1:0]    rot;
   logic                  found;
   logic [PTR_BITS-1:0]   sel;
   logic [PTR_BITS:0]     sum;
   logic [SIZE-1:0]       sel_flit;

   // A port is pending while its request toggle differs from our ack toggle.
   // Rotating by ptr puts the highest-priority port at bit 0 of rot.
   assign pending = in_req ^ in_ack_q;
   assign rot     = N_PORTS'({pending, pending} >> ptr_q);

   // Pick the first pending port at or after ptr, wrapping modulo N_PORTS.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      sum   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, ptr_q} + (PTR_BITS+1)'(k);
            if (sum >= (PTR_BITS+1)'(N_PORTS)) begin
               sum = sum - (PTR_BITS+1)'(N_PORTS);
            end
            sel = sum[PTR_BITS-1:0];
         end
      end
   end

   // Route the selected port's flit toward the output register.
   always_comb begin
      sel_flit = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (sel == PTR_BITS'(k)) begin
            sel_flit = in_data[k*SIZE +: SIZE];
         end
      end
   end

   // Grant in IDLE, then wait for the downstream ack and return it upstream.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      in_ack_d   = in_ack_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      grant_d    = grant_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               out_data_d = sel_flit;
               grant_d    = sel;
               out_req_d  = ~out_req_q;
               busy_d     = 1'b1;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (out_ack == out_req_q) begin
               for (int k = 0; k < N_PORTS; k++) begin
                  if (grant_q == PTR_BITS'(k)) begin
                     in_ack_d[k] = ~in_ack_q[k];
                  end
               end
               ptr_d   = (grant_q == PTR_BITS'(N_PORTS-1)) ? '0 : grant_q + 1'b1;
               cnt_d   = cnt_q + 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any outstanding transaction at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         in_ack_q   <= '0;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         in_ack_q   <= in_ack_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ack     = in_ack_q;
   assign out_req    = out_req_q;
   assign out_data   = out_data_q;
   assign grant_id   = grant_q;
   assign busy       = busy_q;
   assign xfer_count = cnt_q;

endmodule
